ws_keyscan: RTL

//  Keyboard matrix scanner for the HP67 calculator core; sits upstream of the CPU keyboard interface.

---
 rtl/ws_keyscan.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ws_keyscan.sv
// HP67 keyboard matrix scanner: walks 11 open-drain columns, debounces a single key and
// hands a 6-bit {col,row} keycode to the CPU on a valid/ack pair; a press that finds valid still high is dropped with overrun_o.
module ws_keyscan #(
   parameter int SETTLE_CYCLES  = 64,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk_in,
   input  logic        reset_in,
   output logic [10:0] col_drive_o,
   input  logic [3:0]  rowsl_in,
   input  logic [3:0]  rowsr_in,
   output logic [5:0]  key_code_o,
   output logic        key_valid_o,
   input  logic        key_ack_in,
   output logic        key_down_o,
   output logic        overrun_o
);
   localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]    DEB_MAX     = 4'(DEBOUNCE_SCANS);
   localparam logic [3:0]    LAST_COL    = 4'd10;

   typedef enum logic [1:0] {
      ST_DRIVE  = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_EVAL   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [3:0]    col_q, col_d;
   logic [10:0]   col_drive_q, col_drive_d;
   logic [3:0]    rowsl_m_q, rowsl_m_d, rowsl_s_q, rowsl_s_d;
   logic [3:0]    rowsr_m_q, rowsr_m_d, rowsr_s_q, rowsr_s_d;
   logic [1:0]    hit_cnt_q, hit_cnt_d;
   logic [5:0]    hit_code_q, hit_code_d;
   logic [5:0]    cand_q, cand_d;
   logic          cand_vld_q, cand_vld_d;
   logic [3:0]    press_q, press_d;
   logic [3:0]    rel_q, rel_d;
   logic [5:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_down_q, key_down_d;
   logic          overrun_q, overrun_d;

   logic [3:0]    rows_sel;
   logic [2:0]    low_cnt;
   logic [1:0]    low_row;
   logic [2:0]    hit_sum;
   logic          deliver;

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      col_d       = col_q;
      rowsl_m_d   = rowsl_in;
      rowsl_s_d   = rowsl_m_q;
      rowsr_m_d   = rowsr_in;
      rowsr_s_d   = rowsr_m_q;
      hit_cnt_d   = hit_cnt_q;
      hit_code_d  = hit_code_q;
      cand_d      = cand_q;
      cand_vld_d  = cand_vld_q;
      press_d     = press_q;
      rel_d       = rel_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      key_down_d  = key_down_q;
      overrun_d   = 1'b0;
      deliver     = 1'b0;

      rows_sel = (col_q < 4'd6) ? rowsl_s_q : rowsr_s_q;
      low_cnt  = 3'd0;
      low_row  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_sel[i]) begin
            low_cnt = low_cnt + 3'd1;
            low_row = 2'(i);
         end
      end
      hit_sum = {1'b0, hit_cnt_q} + low_cnt;

      case (state_q)
         ST_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            hit_cnt_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            if (hit_cnt_q == 2'd0 && low_cnt == 3'd1) begin
               hit_code_d = {col_q, low_row};
            end
            if (col_q == LAST_COL) begin
               col_d   = 4'd0;
               state_d = ST_EVAL;
            end else begin
               col_d   = col_q + 4'd1;
               state_d = ST_DRIVE;
            end
         end
         ST_EVAL: begin
            state_d   = ST_DRIVE;
            col_d     = 4'd0;
            hit_cnt_d = 2'd0;
            if (hit_cnt_q == 2'd1) begin
               rel_d = 4'd0;
               if (cand_vld_q && hit_code_q == cand_q) begin
                  press_d = (press_q == DEB_MAX) ? press_q : press_q + 4'd1;
               end else begin
                  cand_d     = hit_code_q;
                  cand_vld_d = 1'b1;
                  press_d    = 4'd1;
               end
               // Holding, or swapping keys while down, never re-delivers.
               if (press_d == DEB_MAX && !key_down_q) begin
                  deliver    = 1'b1;
                  key_down_d = 1'b1;
               end
            end else if (hit_cnt_q == 2'd0) begin
               press_d = 4'd0;
               rel_d   = (rel_q == DEB_MAX) ? rel_q : rel_q + 4'd1;
               if (rel_d == DEB_MAX) begin
                  key_down_d = 1'b0;
                  cand_vld_d = 1'b0;
                  cand_d     = 6'd0;
               end
            end
         end
         default: state_d = ST_DRIVE;
      endcase

      if (deliver) begin
         if (!key_valid_q || key_ack_in) begin
            key_code_d  = hit_code_q;
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_valid_q && key_ack_in) begin
         key_valid_d = 1'b0;
      end

      col_drive_d = (state_d == ST_EVAL) ? 11'd0 : (11'd1 << col_d);
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q     <= ST_DRIVE;
         settle_q    <= '0;
         col_q       <= 4'd0;
         col_drive_q <= 11'd0;
         rowsl_m_q   <= 4'hF;
         rowsl_s_q   <= 4'hF;
         rowsr_m_q   <= 4'hF;
         rowsr_s_q   <= 4'hF;
         hit_cnt_q   <= 2'd0;
         hit_code_q  <= 6'd0;
         cand_q      <= 6'd0;
         cand_vld_q  <= 1'b0;
         press_q     <= 4'd0;
         rel_q       <= 4'd0;
         key_code_q  <= 6'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         col_q       <= col_d;
         col_drive_q <= col_drive_d;
         rowsl_m_q   <= rowsl_m_d;
         rowsl_s_q   <= rowsl_s_d;
         rowsr_m_q   <= rowsr_m_d;
         rowsr_s_q   <= rowsr_s_d;
         hit_cnt_q   <= hit_cnt_d;
         hit_code_q  <= hit_code_d;
         cand_q      <= cand_d;
         cand_vld_q  <= cand_vld_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         overrun_q   <= overrun_d;
      end
   end

   assign col_drive_o = col_drive_q;
   assign key_code_o  = key_code_q;
   assign key_valid_o = key_valid_q;
   assign key_down_o  = key_down_q;
   assign overrun_o   = overrun_q;

endmodule
